// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants and the round-and-saturate helper used by the FIR output
// requantizer. This package has no ports.
//   SAMPLE_W / ACC_W   : output sample width / filter accumulator output width
//   SAT_MAX / SAT_MIN  : clipping limits of the requantized sample
//   round_sat()        : round-half-up right shift followed by saturation
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int SAMPLE_W = 8;
    localparam int ACC_W    = 16;
    localparam int SAT_MAX  = 127;
    localparam int SAT_MIN  = -128;

    // Requantized sample plus a flag telling whether saturation clipped it.
    typedef struct packed {
        logic                       clipped;
        logic signed [SAMPLE_W-1:0] value;
    } requant_t;

    // Adds half an LSB of the target scale, shifts arithmetically (floor), then
    // clips. One extra bit of headroom keeps y + 2^(shift-1) from wrapping.
    function automatic requant_t round_sat(input logic signed [ACC_W-1:0] y,
                                           input int                      shift);
        localparam logic signed [ACC_W:0] WIDE_MAX = (ACC_W + 1)'(SAT_MAX);
        localparam logic signed [ACC_W:0] WIDE_MIN = (ACC_W + 1)'(SAT_MIN);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] shifted;
        requant_t              res;

        ext = {y[ACC_W-1], y};
        rnd = (shift > 0) ? ((ACC_W + 1)'(1) << (shift - 1)) : '0;
        sum = ext + rnd;
        shifted = (shift > 0) ? (sum >>> shift) : ext;

        res.clipped = 1'b0;
        res.value   = shifted[SAMPLE_W-1:0];
        if (shifted > WIDE_MAX) begin
            res.clipped = 1'b1;
            res.value   = SAMPLE_W'(SAT_MAX);
        end else if (shifted < WIDE_MIN) begin
            res.clipped = 1'b1;
            res.value   = SAMPLE_W'(SAT_MIN);
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy flags.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   wr_en, wr_data     : write request; accepted when not full, or when full
//                        and a read is accepted in the same cycle
//   rd_en              : pop request; ignored while empty
//   rd_data            : head entry, forced to 0 while empty
//   full, empty        : registered status flags
// Parameters: WIDTH (entry width), DEPTH (entries, power of two >= 2).
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push;
    logic             pop;

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pop      = rd_en && !empty_q;
        push     = wr_en && (!full_q || pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale entries are
    // unreachable once the pointers and count clear, and leaving it out keeps
    // the array mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/fir_out_requant.sv
// -----------------------------------------------------------------------------
// fir_out_requant
// Decimates a FIR output stream by R, rounds/saturates each kept sample from
// 16 to 8 bits and buffers it in a small FIFO toward a ready/valid consumer.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   y_in/y_valid : filter output sample (signed 16 bit); no backpressure
//   s_out        : FIFO head sample (signed 8 bit), 0 while empty
//   s_valid      : FIFO non-empty
//   s_ready      : consumer accepts s_out
//   overflow     : sticky, a kept sample was dropped because the FIFO was full
//   sat_count    : saturating count of clipped kept samples (only when the
//                  macro FIR_OUT_SAT_CNT_EN is defined)
// Parameters: R (1..16), SHIFT (0..8), DEPTH (power of two >= 2).
// -----------------------------------------------------------------------------
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int R     = 2,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [ACC_W-1:0]    y_in,
    input  logic                       y_valid,
    output logic signed [SAMPLE_W-1:0] s_out,
    output logic                       s_valid,
    input  logic                       s_ready,
    output logic                       overflow
`ifdef FIR_OUT_SAT_CNT_EN
    ,
    output logic [7:0]                 sat_count
`endif
);

    generate
        if (R < 1 || R > 16) begin : g_bad_r
            $error("fir_out_requant: R must be in 1..16");
        end
        if (SHIFT < 0 || SHIFT > 8) begin : g_bad_shift
            $error("fir_out_requant: SHIFT must be in 0..8");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fir_out_requant: DEPTH must be a power of two >= 2");
        end
    endgenerate

    localparam int                DCNT_W   = (R > 1) ? $clog2(R) : 1;
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(R - 1);

    logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
    logic                 overflow_q, overflow_d;
    requant_t             rq;
    logic                 keep;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [SAMPLE_W-1:0]  fifo_rd_data;

    always_comb begin
        rq     = round_sat(y_in, SHIFT);
        keep   = y_valid && (dcnt_q == '0);
        dcnt_d = dcnt_q;
        if (y_valid) begin
            dcnt_d = (dcnt_q == DCNT_MAX) ? '0 : dcnt_q + DCNT_W'(1);
        end
        // Full implies non-empty, so s_ready alone decides whether the head
        // leaves this cycle and makes room for the kept sample.
        drop       = keep && fifo_full && !s_ready;
        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            dcnt_q     <= dcnt_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (keep),
        .wr_data (rq.value),
        .rd_en   (s_ready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign s_out    = fifo_rd_data;
    assign s_valid  = !fifo_empty;
    assign overflow = overflow_q;

`ifdef FIR_OUT_SAT_CNT_EN
    logic [7:0] sat_count_q, sat_count_d;

    // Counts clipping at the point of keeping, so dropped samples count too.
    always_comb begin
        sat_count_d = sat_count_q;
        if (keep && rq.clipped && sat_count_q != 8'hFF) begin
            sat_count_d = sat_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) sat_count_q <= '0;
        else       sat_count_q <= sat_count_d;
    end

    assign sat_count = sat_count_q;
`else
    logic rq_clipped_unused;
    assign rq_clipped_unused = rq.clipped;
`endif

endmodule

// File: doc/fir_out_requant.md
FIR_OUT_REQUANT -- requirements
Module: fir_out_requant

Interface
REQ-001 SHALL have parameter R, default 2: decimation factor; legal range 1..16.
REQ-002 SHALL have parameter SHIFT, default 4: right-shift applied before requantization; legal range 0..8.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port y_in, input, 16 bits, signed: filter output sample.
REQ-007 SHALL have port y_valid, input, 1 bit: y_in valid this cycle; there is no backpressure toward the filter.
REQ-008 SHALL have port s_out, output, 8 bits, signed: FIFO head sample.
REQ-009 SHALL have port s_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port s_ready, input, 1 bit: downstream accepts s_out.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag meaning a kept sample was dropped.
REQ-012 SHALL have port sat_count, output, 8 bits: count of clipped samples; present only with FIR_OUT_SAT_CNT_EN.

Function
REQ-013 SHALL keep a decimation counter dcnt running 0..R-1.
  - dcnt advances only on y_valid and wraps to 0 after R-1.
  - A sample is kept when y_valid=1 and dcnt=0.
  - The first valid sample after reset is therefore kept.
REQ-014 SHALL round each kept sample as follows.
  - Form a 17-bit sum: y_in + 2^(SHIFT-1).
  - Arithmetic-shift the sum right by SHIFT.
  - With SHIFT=0, pass y_in unchanged.
REQ-015 SHALL saturate the rounded value to the range -128..127.
REQ-016 SHALL write the kept, requantized sample into the FIFO in the same cycle it is kept.
  - With the FIFO empty, s_valid rises the next cycle (latency 1).
REQ-017 SHALL pop the FIFO head when s_valid=1 and s_ready=1.
  - Output order SHALL be FIFO order.
  - s_out is don't-care while s_valid=0.
REQ-018 SHALL accept a write when the FIFO is full and a pop occurs in the same cycle; no overflow results.
REQ-019 SHALL, when the FIFO is full and there is no pop:
  - drop the kept sample;
  - set overflow to 1 on the next cycle;
  - still advance dcnt.
REQ-020 SHALL hold overflow at 1 until reset.
REQ-021 SHALL have no effect from s_ready while the FIFO is empty.
REQ-022 SHALL leave the FIFO unchanged while y_valid=0.

Reset
REQ-023 SHALL, on a reset-high clock edge, set:
  - s_valid=0, s_out=0, overflow=0;
  - dcnt=0 and FIFO pointers/count to 0;
  - sat_count=0 when present.
REQ-024 SHALL discard FIFO contents on reset mid-operation; s_valid is 0 in the cycle after the reset edge.
REQ-025 SHALL give reset priority over y_valid and s_ready in the same cycle.

Configuration
REQ-026 SHALL compile the saturation counter in or out with macro FIR_OUT_SAT_CNT_EN.
REQ-027 SHALL, with FIR_OUT_SAT_CNT_EN defined:
  - add output sat_count;
  - increment sat_count once per kept sample that was clipped, including samples later dropped;
  - hold sat_count at 255 once reached.
REQ-028 SHALL, without the macro, omit the sat_count port and its logic; all other behaviour is identical.

Structure
REQ-029 SHALL take the following from shared package fir_pkg:
  - SAMPLE_W=8 and ACC_W=16;
  - SAT_MAX=127 and SAT_MIN=-128;
  - the round-and-saturate function.
REQ-030 SHALL instantiate the FIFO as sub-module sync_fifo, parameterized by width and DEPTH, with registered count/full/empty.
REQ-031 SHALL check parameter legality at elaboration.

Verification (R=2, SHIFT=4, DEPTH=4 unless noted)
REQ-032 SHALL cover basic path.
  - Stimulus: reset, s_ready=1, then y_in=24 and y_in=40 on consecutive valid cycles.
  - Response: exactly one output, s_out=2, s_valid high one cycle after the first sample; the second sample is skipped.
REQ-033 SHALL cover negative rounding.
  - Stimulus: kept samples y_in=-24 and then y_in=-25.
  - Response: s_out=-1, then s_out=-2.
REQ-034 SHALL cover saturation.
  - Stimulus: kept samples y_in=0x7FFF and then 0x8000.
  - Response: s_out=127, then -128; sat_count=2 with macro defined.
REQ-035 SHALL cover backpressure and overflow.
  - Stimulus: s_ready=0, 10 consecutive valid samples 16, 32, ... 160.
  - Response: 5 kept, 4 stored, overflow=1 after the 5th kept sample.
  - Then with s_ready=1: outputs 1, 3, 5, 7 in order, and overflow remains 1.
REQ-036 SHALL cover full FIFO with simultaneous pop.
  - Stimulus: FIFO holds 4 samples; s_ready=1 in the same cycle as a kept sample.
  - Response: write accepted, overflow stays 0, 5 outputs delivered in order.
REQ-037 SHALL cover reset mid-stream.
  - Stimulus: FIFO holding 3 samples, dcnt=1; assert reset for one cycle.
  - Response: s_valid=0, overflow=0, and the next valid sample is kept.
